// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the two-requester APB master arbiter:
//   - apb_state_e : APB master FSM state encoding (IDLE / SETUP / ACCESS)
//   - DEF_ADDR_W, DEF_DATA_W, DEF_TIMEOUT : default parameter values
//   - WAIT_W      : width of the ACCESS wait counter (covers TIMEOUT <= 255)
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int WAIT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage : apb_arb_pkg

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin arbiter with a one-hot combinational grant.
// A lone requester always wins; on a tie the requester holding priority wins.
// Priority moves to the other requester whenever a grant is accepted.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset (requester 0 gets first tie)
//   req_i     : request vector, bit i = requester i
//   advance_i : current grant was accepted this cycle
//   grant_o   : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // prio_q = 0: requester 0 wins a tie; prio_q = 1: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  // One-hot grant selection
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Hand priority to the requester that was not just served
  always_comb begin
    prio_d = prio_q;
    if (advance_i && grant_o[0]) begin
      prio_d = 1'b1;
    end else if (advance_i && grant_o[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : apb_rr_arbiter

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Arbitrates two simple valid/ready requesters onto a single APB master port.
// Each accepted request becomes one APB transfer (SETUP then ACCESS); the
// completion is reported to the owning requester as a one-cycle rsp_valid
// pulse. A wait counter forces an error completion after TIMEOUT consecutive
// not-ready ACCESS cycles. Back-to-back transfers skip IDLE.
// Ports:
//   PCLK, PRESETn       : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready combinational)
//   req_write/addr/wdata: per-requester transfer fields (slice i = requester i)
//   rsp_valid/rdata/err : registered completion to the owner
//   PSELx..PWDATA       : registered APB master outputs
//   PRDATA/PREADY/PSLVERR: APB completer response
// -----------------------------------------------------------------------------
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  // Counter value seen during the TIMEOUT-th consecutive wait cycle
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                owner_q, owner_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [1:0]          grant_s;
  logic                in_access_s;
  logic                timeout_s;
  logic                complete_s;
  logic                can_accept_s;
  logic                accept_s;
  logic                win_idx_s;
  logic                win_write_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_wdata_s;

  apb_rr_arbiter u_rr (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .req_i     (req_valid),
    .advance_i (accept_s),
    .grant_o   (grant_s)
  );

  // Handshake: a new request is only taken in IDLE or on the completing ACCESS cycle
  always_comb begin
    in_access_s  = (state_q == ST_ACCESS);
    timeout_s    = in_access_s && !PREADY && (wait_cnt_q == TIMEOUT_LAST);
    complete_s   = in_access_s && (PREADY || timeout_s);
    can_accept_s = (state_q == ST_IDLE) || complete_s;
    req_ready    = can_accept_s ? grant_s : 2'b00;
    accept_s     = |(req_valid & req_ready);
    win_idx_s    = grant_s[1];
    win_write_s  = win_idx_s ? req_write[1] : req_write[0];
    win_addr_s   = win_idx_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    win_wdata_s  = win_idx_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // FSM next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = {DATA_W{1'b0}};
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = {WAIT_W{1'b0}};
        if (accept_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = {WAIT_W{1'b0}};
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (complete_s) begin
          wait_cnt_d  = {WAIT_W{1'b0}};
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          // PREADY low here means the timeout forced completion
          rsp_err_d   = PREADY ? PSLVERR : 1'b1;
          if (PREADY && !pwrite_q) begin
            rsp_rdata_d = PRDATA;
          end else begin
            rsp_rdata_d = {DATA_W{1'b0}};
          end
          if (accept_s) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
          state_d    = ST_ACCESS;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
    endcase

    // Latch the winner's fields; otherwise they hold (including in IDLE)
    if (accept_s) begin
      owner_d  = win_idx_s;
      pwrite_d = win_write_s;
      paddr_d  = win_addr_s;
      pwdata_d = win_wdata_s;
    end else begin
      owner_d  = owner_q;
    end

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= {WAIT_W{1'b0}};
      owner_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      owner_q     <= owner_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule : apb_master_arbiter

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter (TIMEOUT = 4). A vector table drives
// single-requester transfers; hand-written sequences cover reset abort and
// back-to-back round-robin ties.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_addr;

  apb_master_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  mask;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with the DUT in IDLE
  task automatic run_txn(input vec_t v);
    int acc;
    bit done;
    chk("idle_paddr_hold", PADDR, last_addr);
    chk("idle_sel", {PSELx, PENABLE}, 2'b00);
    req_valid = v.mask;
    req_write = v.mask[0] ? {~v.wr, v.wr} : {v.wr, ~v.wr};
    req_addr  = v.mask[0] ? {32'hBAD0_0000, v.addr} : {v.addr, 32'hBAD0_0000};
    req_wdata = v.mask[0] ? {~v.wdata, v.wdata} : {v.wdata, ~v.wdata};
    PREADY    = 1'b0;
    #1 chk("ready", req_ready, v.mask);
    @(negedge PCLK);
    req_valid = 2'b00;
    chk("setup_sel_en", {PSELx, PENABLE}, 2'b10);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    chk("setup_pwdata", PWDATA, v.wdata);
    acc  = 0;
    done = 1'b0;
    while (!done && acc < 20) begin
      @(negedge PCLK);
      if (rsp_valid != 2'b00) begin
        done = 1'b1;
      end else begin
        acc++;
        chk("acc_sel_en", {PSELx, PENABLE}, 2'b11);
        chk("acc_paddr", PADDR, v.addr);
        chk("acc_pwdata", PWDATA, v.wdata);
        PREADY  = (acc > v.waits);
        PRDATA  = v.prdata;
        PSLVERR = v.slverr;
      end
    end
    chk("rsp_seen", done, 1'b1);
    chk("rsp_valid", rsp_valid, v.exp_rsp);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("access_cycles", acc, v.exp_acc);
    chk("post_sel_en", {PSELx, PENABLE}, 2'b00);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    @(negedge PCLK);
    chk("rsp_pulse_end", {rsp_valid, rsp_err}, 3'b000);
    last_addr = v.addr;
  endtask

  initial begin
    int j;
    logic [1:0] exp_rsp;
    logic [1:0] exp_rdy;

    //        mask   wr    addr          wdata         waits prdata        err   rsp    rdata         err   acc
    vecs[0] = '{2'b01, 1'b0, 32'h0000_0010, 32'h0000_0000, 0,  32'hCAFE_0001, 1'b0, 2'b01, 32'hCAFE_0001, 1'b0, 1};
    vecs[1] = '{2'b10, 1'b1, 32'h0000_0020, 32'h0000_0055, 3,  32'h1111_1111, 1'b0, 2'b10, 32'h0000_0000, 1'b0, 4};
    vecs[2] = '{2'b01, 1'b0, 32'h0000_0030, 32'h0000_0000, 0,  32'hDEAD_0BAD, 1'b1, 2'b01, 32'hDEAD_0BAD, 1'b1, 1};
    vecs[3] = '{2'b10, 1'b0, 32'h0000_0040, 32'h0000_0000, 255, 32'hFFFF_FFFF, 1'b0, 2'b10, 32'h0000_0000, 1'b1, 4};
    vecs[4] = '{2'b01, 1'b1, 32'h0000_0050, 32'h0000_ABCD, 1,  32'h7777_7777, 1'b1, 2'b01, 32'h0000_0000, 1'b1, 2};
    vecs[5] = '{2'b10, 1'b0, 32'h0000_0060, 32'h0000_0000, 2,  32'h1234_5678, 1'b0, 2'b10, 32'h1234_5678, 1'b0, 3};

    PRESETn   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 64'h0;
    req_wdata = 64'h0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    last_addr = 32'h0;

    repeat (2) @(negedge PCLK);
    chk("rst_sel_en_wr", {PSELx, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ready", req_ready, 2'b00);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Reset during ACCESS: outputs clear at once, no response ever appears
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr  = {32'h0000_0044, 32'h0};
    req_wdata = {32'h0000_0099, 32'h0};
    @(negedge PCLK);
    req_valid = 2'b00;
    @(negedge PCLK);
    chk("abort_in_access", {PSELx, PENABLE, PWRITE}, 3'b111);
    #2 PRESETn = 1'b0;
    #1;
    chk("abort_sel_en_wr", {PSELx, PENABLE, PWRITE}, 3'b000);
    chk("abort_paddr", PADDR, 32'h0);
    chk("abort_pwdata", PWDATA, 32'h0);
    chk("abort_rsp", {rsp_valid, rsp_err}, 3'b000);
    PREADY = 1'b1;
    PRDATA = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      chk("abort_no_rsp", rsp_valid, 2'b00);
    end
    PRESETn = 1'b1;
    PREADY  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      chk("abort_no_rsp_after", {rsp_valid, PSELx}, 3'b000);
    end

    // Tie after reset: grants alternate 0,1,0,1 with no IDLE between them
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = 64'h0;
    PREADY    = 1'b1;
    PRDATA    = 32'hA5A5_0000;
    #1 chk("tie_first_ready", req_ready, 2'b01);
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      j = k / 2;
      if (k >= 2 && (k % 2) == 0) begin
        exp_rsp = (((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10;
      end else begin
        exp_rsp = 2'b00;
      end
      chk("tie_sel", PSELx, 1'b1);
      chk("tie_penable", PENABLE, (k % 2 == 1));
      chk("tie_paddr", PADDR, (j % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      chk("tie_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != 2'b00) begin
        chk("tie_rsp_rdata", rsp_rdata, 32'hA5A5_0000);
      end
      if (k == 7) begin
        req_valid = 2'b00;
      end
      if ((k % 2) == 0 || k == 7) begin
        exp_rdy = 2'b00;
      end else begin
        exp_rdy = (j % 2 == 0) ? 2'b10 : 2'b01;
      end
      #1 chk("tie_ready", req_ready, exp_rdy);
    end
    @(negedge PCLK);
    chk("tie_last_rsp", rsp_valid, 2'b10);
    chk("tie_end_idle", {PSELx, PENABLE}, 2'b00);
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("tie_pulse_end", rsp_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_apb_master_arbiter
